// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : Hardware call/data stack for PUSH, POP, CALL and RET.
//               One request is accepted per IDLE cycle through a valid/ready
//               handshake. The request is executed against an internal
//               synchronous RAM in EXEC. Completion is reported in RESP with
//               a one-cycle done pulse.
// Ports       : clk, rst          - clock, async active-high reset
//               op_valid/op_ready - request handshake
//               StackOp           - 001 PUSH, 010 POP, 011 CALL, 100 RET
//               regval, PCin      - PUSH data, current PC (CALL stores PC+1)
//               done              - one-cycle completion pulse
//               pop_data          - last value returned by POP/RET
//               overflow/underflow- rejection flags, valid with done
//               stack_fault       - sticky OR of overflow/underflow
//               sp                - entry count / next free slot
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    StackOp,
    input  logic [DW-1:0] regval,
    input  logic [DW-1:0] PCin,
    output logic          done,
    output logic [DW-1:0] pop_data,
    output logic          overflow,
    output logic          underflow,
    output logic          stack_fault,
    output logic [AW:0]   sp
);

    localparam logic [2:0]  C_OP_PUSH = 3'b001;
    localparam logic [2:0]  C_OP_POP  = 3'b010;
    localparam logic [2:0]  C_OP_CALL = 3'b011;
    localparam logic [2:0]  C_OP_RET  = 3'b100;
    localparam logic [AW:0] C_SP_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic          udf_pend_q, udf_pend_d;
    logic          rd_ok_q, rd_ok_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] pop_data_q, pop_data_d;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    logic          w_accept;
    logic          w_is_write;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    // Reserved StackOp codes are not accepted at all, so they never
    // produce a done pulse and never leave IDLE.
    assign w_accept   = op_ready && op_valid &&
                        (StackOp >= C_OP_PUSH) && (StackOp <= C_OP_RET);
    assign w_is_write = (op_q == C_OP_PUSH) || (op_q == C_OP_CALL);
    assign w_full     = (sp_q == C_SP_FULL);
    assign w_empty    = (sp_q == '0);
    assign w_wr_en    = (state_q == S_EXEC) && w_is_write && !w_full;
    assign w_rd_en    = (state_q == S_EXEC) && !w_is_write && !w_empty;
    assign w_wr_addr  = sp_q[AW-1:0];
    assign w_rd_addr  = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        ovf_pend_d = ovf_pend_q;
        udf_pend_d = udf_pend_q;
        rd_ok_d    = rd_ok_q;
        fault_d    = fault_q;
        pop_data_d = pop_data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = StackOp;
                    wdata_d = (StackOp == C_OP_CALL) ? PCin + DW'(1) : regval;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ovf_pend_d = w_is_write && w_full;
                udf_pend_d = !w_is_write && w_empty;
                rd_ok_d    = w_rd_en;
                if (w_wr_en) begin
                    sp_d = sp_q + (AW + 1)'(1);
                end else if (w_rd_en) begin
                    sp_d = sp_q - (AW + 1)'(1);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                fault_d = fault_q | ovf_pend_q | udf_pend_q;
                if (rd_ok_q) begin
                    pop_data_d = rd_data_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sp_q       <= '0;
            op_q       <= '0;
            wdata_q    <= '0;
            ovf_pend_q <= 1'b0;
            udf_pend_q <= 1'b0;
            rd_ok_q    <= 1'b0;
            fault_q    <= 1'b0;
            pop_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            ovf_pend_q <= ovf_pend_d;
            udf_pend_q <= udf_pend_d;
            rd_ok_q    <= rd_ok_d;
            fault_q    <= fault_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Stack RAM: contents survive reset; read data is registered.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= wdata_q;
        end
        if (w_rd_en) begin
            rd_data_q <= mem[w_rd_addr];
        end
    end

    // Response outputs are decoded from flops only.
    assign op_ready    = (state_q == S_IDLE) && !rst;
    assign done        = (state_q == S_RESP);
    assign overflow    = (state_q == S_RESP) && ovf_pend_q;
    assign underflow   = (state_q == S_RESP) && udf_pend_q;
    assign stack_fault = fault_q;
    assign pop_data    = pop_data_q;
    assign sp          = sp_q;

endmodule
`default_nettype wire
